// File: rtl/paralelo_serial.sv
// Parallel-in, serial-out shift register with valid/ready load and serial handshakes.
// Bit order is latched per word; back-to-back words stream with no idle gap.
module paralelo_serial #(
    parameter int WIDTH = 6,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             msb_first,
    input  logic             serial_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_first,
    output logic             serial_last,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             dir;
    logic             first;
    logic             cnt_zero;
    logic             consume;
    logic             accept;

    assign cnt_zero = (cnt == '0);
    assign accept   = load_valid & load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_ready   = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        serial_first = 1'b0;
        serial_last  = 1'b0;
        busy         = 1'b0;
        consume      = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                serial_valid = 1'b1;
                busy         = 1'b1;
                serial_out   = dir ? sreg[WIDTH-1] : sreg[0];
                serial_first = first;
                serial_last  = cnt_zero;
                consume      = serial_ready;
                // Next word may only load while the final bit leaves.
                load_ready   = cnt_zero & serial_ready;
                if (serial_ready && cnt_zero && !load_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg  <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            first <= 1'b0;
        end else if (accept) begin
            sreg  <= load_data;
            cnt   <= CNT_MAX;
            dir   <= msb_first;
            first <= 1'b1;
        end else if (consume) begin
            sreg  <= dir ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            first <= 1'b0;
            if (!cnt_zero) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: table of words plus hand-written corner sequences,
// serial bits checked against a scoreboard filled at word acceptance.
module tb_paralelo_serial;

    localparam int W = 6;

    typedef struct {
        logic [W-1:0] data;
        logic         msb;
        logic [W-1:0] seq;
    } vec_t;

    typedef struct {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         msb_first;
    logic         serial_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         serial_first;
    logic         serial_last;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int valid_cycles;
    logic [W-1:0] cur_seq;
    logic [W-1:0] rx;
    exp_t sb[$];
    vec_t vecs[5];

    paralelo_serial #(.WIDTH(W), .CW(3)) dut (
        .clk(clk),
        .reset(reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data(load_data),
        .msb_first(msb_first),
        .serial_ready(serial_ready),
        .serial_out(serial_out),
        .serial_valid(serial_valid),
        .serial_first(serial_first),
        .serial_last(serial_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: check outputs at negedge, record acceptance, advance past posedge.
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        if (serial_valid) valid_cycles++;
        if (sb.size() != 0) chk("valid_while_pending", serial_valid, 1);
        chk("busy_eq_valid", busy, serial_valid);
        if (serial_valid && serial_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("bit", serial_out, e.b);
                chk("first", serial_first, e.f);
                chk("last", serial_last, e.l);
                rx = {serial_out, rx[W-1:1]};
            end
        end
        acc = load_valid && load_ready;
        if (acc) begin
            for (int i = W - 1; i >= 0; i--) begin
                sb.push_back('{b: cur_seq[i], f: (i == W - 1), l: (i == 0)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic m, input logic [W-1:0] s);
        bit acc = 0;
        load_valid = 1'b1;
        load_data  = d;
        msb_first  = m;
        cur_seq    = s;
        for (int i = 0; i < 20 && !acc; i++) step(acc);
        if (!acc) chk("accept_timeout", 0, 1);
        load_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step(acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic idle_chk(input string name);
        @(negedge clk);
        chk({name, "_valid"}, serial_valid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ready"}, load_ready, 1);
        chk({name, "_out"}, serial_out, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int n;
        vecs[0] = '{data: 6'b101100, msb: 1'b1, seq: 6'b101100};
        vecs[1] = '{data: 6'b000011, msb: 1'b0, seq: 6'b110000};
        vecs[2] = '{data: 6'b100110, msb: 1'b1, seq: 6'b100110};
        vecs[3] = '{data: 6'b011001, msb: 1'b0, seq: 6'b100110};
        vecs[4] = '{data: 6'b111000, msb: 1'b0, seq: 6'b000111};

        reset        = 1'b1;
        load_valid   = 1'b0;
        load_data    = '0;
        msb_first    = 1'b0;
        serial_ready = 1'b1;
        cur_seq      = '0;
        rx           = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_first", serial_first, 0);
        chk("rst_last", serial_last, 0);
        @(posedge clk);
        #1;
        idle_chk("rst");

        for (int v = 0; v < 5; v++) begin
            send(vecs[v].data, vecs[v].msb, vecs[v].seq);
            drain();
            if (v == 1) chk("lsb_recovered", rx, 6'b000011);
            idle_chk("after_vec");
        end

        // Back-to-back frames with zero gap
        send(6'b111000, 1'b1, 6'b111000);
        load_valid = 1'b1;
        load_data  = 6'b010101;
        cur_seq    = 6'b010101;
        acc = 0;
        n = 0;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        chk("b2b_accept_bit", n, 6);
        load_valid = 1'b0;
        drain();
        idle_chk("b2b");

        // Stalls on bits 2 and 3
        send(6'b100110, 1'b1, 6'b100110);
        valid_cycles = 0;
        step(acc);
        for (int k = 0; k < 2; k++) begin
            serial_ready = 1'b0;
            step(acc);
            step(acc);
            @(negedge clk);
            chk("stall_hold", serial_out, 0);
            @(posedge clk);
            #1;
            serial_ready = 1'b1;
            step(acc);
        end
        drain();
        chk("stall_frame_len", valid_cycles, 10);
        idle_chk("stall");

        // Mid-frame load attempt with direction change
        send(6'b110010, 1'b1, 6'b110010);
        step(acc);
        step(acc);
        load_valid = 1'b1;
        load_data  = 6'b111111;
        msb_first  = 1'b0;
        #1;
        chk("mid_ready_low", load_ready, 0);
        cur_seq = 6'b111111;
        acc = 0;
        n = 0;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        chk("mid_accept_bit", n, 4);
        load_valid = 1'b0;
        drain();
        idle_chk("mid");

        // Reset at bit 4
        send(6'b101010, 1'b1, 6'b101010);
        repeat (3) step(acc);
        reset = 1'b1;
        step(acc);
        reset = 1'b0;
        sb.delete();
        idle_chk("midrst");
        send(6'b011001, 1'b0, 6'b100110);
        drain();
        idle_chk("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
